serial_cmd_decoder: RTL

- Sits between the UART byte receiver/transmitter and `controller_fsm`.
- Assembles host command frames from RX bytes and issues `cmd`/`addr`/`wr_data` with an `in_valid` pulse.
- Waits for the controller to finish, then sends the reply bytes, including MCU read data, through the UART TX.

---
 rtl/debug_pkg.sv | 49 ++++
 rtl/tx_byte_seq.sv | 37 +++
 rtl/serial_cmd_decoder.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/debug_pkg.sv
// Shared debug-link definitions: controller command codes, reply bytes,
// serial decoder state encoding and frame-format helpers.
package debug_pkg;

  localparam logic [3:0] FN_NONE        = 4'h0;
  localparam logic [3:0] FN_PAUSE       = 4'h1;
  localparam logic [3:0] FN_RESUME      = 4'h2;
  localparam logic [3:0] FN_STEP        = 4'h3;
  localparam logic [3:0] FN_RESET       = 4'h4;
  localparam logic [3:0] FN_STATUS      = 4'h5;
  localparam logic [3:0] FN_MEM_RD_BYTE = 4'h6;
  localparam logic [3:0] FN_MEM_RD_WORD = 4'h7;
  localparam logic [3:0] FN_REG_RD      = 4'h8;
  localparam logic [3:0] FN_BR_PT_ADD   = 4'h9;
  localparam logic [3:0] FN_BR_PT_RM    = 4'hA;
  localparam logic [3:0] FN_MEM_WR_BYTE = 4'hB;
  localparam logic [3:0] FN_MEM_WR_WORD = 4'hC;
  localparam logic [3:0] FN_REG_WR      = 4'hD;

  localparam logic [7:0] REPLY_ACK = 8'hAA;
  localparam logic [7:0] REPLY_NAK = 8'hFF;

  typedef enum logic [2:0] {
    S_CMD,
    S_ADDR,
    S_DATA,
    S_ISSUE,
    S_WAIT,
    S_TX,
    S_TX_GUARD
  } dec_state_t;

  function automatic logic cmd_is_valid(input logic [3:0] code);
    return (code >= FN_PAUSE) && (code <= FN_REG_WR);
  endfunction

  function automatic logic cmd_has_addr(input logic [3:0] code);
    return (code >= FN_MEM_RD_BYTE) && (code <= FN_REG_WR);
  endfunction

  function automatic logic cmd_has_data(input logic [3:0] code);
    return (code >= FN_MEM_WR_BYTE) && (code <= FN_REG_WR);
  endfunction

  function automatic logic cmd_is_read(input logic [3:0] code);
    return (code >= FN_MEM_RD_BYTE) && (code <= FN_REG_RD);
  endfunction

endpackage

// File: rtl/tx_byte_seq.sv
// Reply byte sequencer: holds up to four reply bytes and releases them one at
// a time, MSB byte first, through the UART tx_start/tx_busy handshake.
module tx_byte_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [31:0] i_bytes,
  input  logic [2:0]  i_count,
  input  logic        i_send_en,
  input  logic        i_tx_busy,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_start,
  output logic        o_more
);

  logic [31:0] r_shift;
  logic [2:0]  r_left;

  assign o_tx_start = i_send_en && !i_tx_busy && (r_left != 3'd0);
  assign o_tx_data  = r_shift[31:24];
  assign o_more     = (r_left != 3'd0);

  // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_left  <= '0;
    end else if (i_load) begin
      r_shift <= i_bytes;
      r_left  <= i_count;
    end else if (o_tx_start) begin
      r_shift <= {r_shift[23:0], 8'h00};
      r_left  <= r_left - 3'd1;
    end
  end

endmodule

// File: rtl/serial_cmd_decoder.sv
// Host command frame decoder between the UART and controller_fsm.
// Define SDEC_TIMEOUT_EN to abort partial frames after an inter-byte gap.
module serial_cmd_decoder
  import debug_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TIMEOUT_MS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [3:0]  cmd,
  output logic [31:0] addr,
  output logic [31:0] wr_data,
  output logic        in_valid,
  input  logic        ctrlr_busy,
  input  logic [31:0] rd_data,
  output logic        dec_busy
);

  dec_state_t  r_state, w_next;
  logic [1:0]  r_cnt;
  logic [3:0]  r_cmd;
  logic [31:0] r_addr, r_wr_data;
  logic        w_load;
  logic [31:0] w_load_bytes;
  logic [2:0]  w_load_cnt;
  logic        w_tx_start, w_more, w_timeout;

`ifdef SDEC_TIMEOUT_EN
  localparam int TIMEOUT_CYC = CLK_HZ / 1000 * TIMEOUT_MS;
  localparam int TO_W        = $clog2(TIMEOUT_CYC + 1);

  logic [TO_W-1:0] r_to_cnt;
  logic            w_in_frame;

  assign w_in_frame = (r_state == S_ADDR) || (r_state == S_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_to_cnt <= '0;
    else if (!w_in_frame || rx_valid) r_to_cnt <= '0;
    else                            r_to_cnt <= r_to_cnt + TO_W'(1);
  end

  // A byte arriving on the expiry cycle still belongs to the frame.
  assign w_timeout = w_in_frame && !rx_valid && (r_to_cnt == TO_W'(TIMEOUT_CYC));
`else
  assign w_timeout = 1'b0;
`endif

  assign cmd      = r_cmd;
  assign addr     = r_addr;
  assign wr_data  = r_wr_data;
  assign in_valid = (r_state == S_ISSUE) && !ctrlr_busy;
  assign dec_busy = (r_state != S_CMD);
  assign tx_start = w_tx_start;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    w_next       = r_state;
    w_load       = 1'b0;
    w_load_bytes = '0;
    w_load_cnt   = '0;
    case (r_state)
      S_CMD: if (rx_valid) begin
        if (!cmd_is_valid(rx_data[3:0])) begin
          w_next       = S_TX;
          w_load       = 1'b1;
          w_load_bytes = {REPLY_NAK, 24'h0};
          w_load_cnt   = 3'd1;
        end else if (cmd_has_addr(rx_data[3:0])) begin
          w_next = S_ADDR;
        end else begin
          w_next = S_ISSUE;
        end
      end
      S_ADDR: begin
        if (rx_valid && (r_cnt == 2'd3)) w_next = cmd_has_data(r_cmd) ? S_DATA : S_ISSUE;
        else if (w_timeout)              w_next = S_CMD;
      end
      S_DATA: begin
        if (rx_valid && (r_cnt == 2'd3)) w_next = S_ISSUE;
        else if (w_timeout)              w_next = S_CMD;
      end
      S_ISSUE: if (!ctrlr_busy) w_next = S_WAIT;
      S_WAIT: if (!ctrlr_busy) begin
        w_next = S_TX;
        w_load = 1'b1;
        if (cmd_is_read(r_cmd)) begin
          w_load_bytes = rd_data;
          w_load_cnt   = 3'd4;
        end else begin
          w_load_bytes = {REPLY_ACK, 24'h0};
          w_load_cnt   = 3'd1;
        end
      end
      S_TX:       if (w_tx_start) w_next = S_TX_GUARD;
      S_TX_GUARD: w_next = w_more ? S_TX : S_CMD;
      default:    w_next = S_CMD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_CMD;
      r_cnt     <= '0;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_wr_data <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_CMD: if (rx_valid) begin
          r_cmd <= rx_data[3:0];
          r_cnt <= '0;
        end
        S_ADDR: begin
          if (rx_valid) begin
            r_addr <= {r_addr[23:0], rx_data};
            r_cnt  <= r_cnt + 2'd1;
          end else if (w_timeout) begin
            r_cnt <= '0;
          end
        end
        S_DATA: begin
          if (rx_valid) begin
            r_wr_data <= {r_wr_data[23:0], rx_data};
            r_cnt     <= r_cnt + 2'd1;
          end else if (w_timeout) begin
            r_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  tx_byte_seq u_tx_seq (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_bytes    (w_load_bytes),
    .i_count    (w_load_cnt),
    .i_send_en  (r_state == S_TX),
    .i_tx_busy  (tx_busy),
    .o_tx_data  (tx_data),
    .o_tx_start (w_tx_start),
    .o_more     (w_more)
  );

endmodule
